// File: rtl/useq_ctl.sv
// Microcode sequencer: computes the next microcode address for a 1-cycle synchronous ROM,
// with micro-subroutine stack, polled WAIT, RDY stall and edge-latched NMI over level IRQ.
module useq_ctl #(
  parameter int                ADDR_W  = 9,
  parameter int                CTRL_W  = 36,
  parameter int                SEQ_LSB = 22,
  parameter int                FIN_LSB = 10,
  parameter int                WE_BIT  = 28,
  parameter int                B_BIT   = 8,
  parameter int                STK_D   = 4,
  parameter logic [ADDR_W-1:0] RST_VEC = 'h160,
  parameter logic [ADDR_W-1:0] NMI_VEC = 'h170,
  parameter logic [ADDR_W-1:0] IRQ_VEC = 'h168
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdy,
  input  logic              irq,
  input  logic              nmi,
  input  logic              I,
  input  logic              D,
  input  logic              cond,
  input  logic [ADDR_W-2:0] DB,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [ADDR_W-1:0] upc,
  output logic              sync,
  output logic              WE,
  output logic              B,
  output logic [1:0]        int_ack,
  output logic              err
);

  localparam int LINK_W = ADDR_W - 2;
  localparam int FIN_W  = ADDR_W - 4;
  localparam int SP_W   = $clog2(STK_D + 1);
  localparam int IDX_W  = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STK_D);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STK_D - 1);

  typedef enum logic [2:0] {
    OP_DECODE = 3'b000,
    OP_NEXT   = 3'b001,
    OP_FINISH = 3'b010,
    OP_NSAVE  = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_WAIT   = 3'b110,
    OP_ILL    = 3'b111
  } seq_op_t;

  seq_op_t           seq_op;
  logic [LINK_W-1:0] link;
  logic [FIN_W-1:0]  fin;
  logic              unused_ctrl;

  logic [ADDR_W-1:0] upc_q;
  logic [FIN_W-1:0]  finish;
  logic [ADDR_W-1:0] stack [STK_D];
  logic [SP_W-1:0]   sp;
  logic              we_q;
  logic [1:0]        int_ack_q;
  logic              err_q;
  logic              nmi_q;
  logic              nmi_pend;

  logic [ADDR_W-1:0] upc_n;
  logic [ADDR_W-1:0] jump;
  logic [ADDR_W-1:0] ret_addr;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              stk_full;
  logic              stk_empty;
  logic              take_nmi;
  logic              take_irq;
  logic              push;
  logic              pop;
  logic              ld_fin;
  logic              fault;
  logic              fetch;
  logic              nmi_edge;

  assign seq_op      = seq_op_t'(ctrl[SEQ_LSB +: 3]);
  assign link        = ctrl[LINK_W-1:0];
  assign fin         = ctrl[FIN_LSB +: FIN_W];
  assign unused_ctrl = ^ctrl;

  assign jump      = {1'b1, D, link};
  assign ret_addr  = upc_q + ADDR_W'(1);
  assign stk_full  = (sp == SP_FULL);
  assign stk_empty = (sp == '0);
  assign top_idx   = IDX_W'(sp - SP_W'(1));
  // A push into a full stack lands on the top entry instead of growing the stack.
  assign wr_idx    = stk_full ? IDX_LAST : IDX_W'(sp);
  assign nmi_edge  = nmi & ~nmi_q;

  always_comb begin
    upc_n    = upc_q;
    take_nmi = 1'b0;
    take_irq = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    ld_fin   = 1'b0;
    fault    = 1'b0;
    fetch    = 1'b0;
    if (rdy) begin
      case (seq_op)
        OP_DECODE, OP_ILL: begin
          fetch = 1'b1;
          fault = (seq_op == OP_ILL);
          if (nmi_pend) begin
            upc_n    = NMI_VEC;
            take_nmi = 1'b1;
          end else if (irq && !I) begin
            upc_n    = IRQ_VEC;
            take_irq = 1'b1;
          end else begin
            upc_n = {1'b0, DB};
          end
        end
        OP_NEXT:   upc_n = jump;
        OP_FINISH: upc_n = {1'b1, D, 2'b10, finish};
        OP_NSAVE: begin
          upc_n  = jump;
          ld_fin = 1'b1;
        end
        OP_CALL: begin
          upc_n = jump;
          push  = 1'b1;
          fault = stk_full;
        end
        OP_RET: begin
          pop = 1'b1;
          if (stk_empty) begin
            upc_n = RST_VEC;
            fault = 1'b1;
          end else begin
            upc_n = stack[top_idx];
          end
        end
        OP_WAIT:   upc_n = cond ? jump : upc_q;
        default:   upc_n = upc_q;
      endcase
    end
  end

  assign upc     = reset ? RST_VEC : upc_n;
  assign sync    = ~reset & fetch & ~take_nmi & ~take_irq;
  assign WE      = we_q;
  assign B       = ctrl[B_BIT];
  assign int_ack = int_ack_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q     <= RST_VEC;
      we_q      <= 1'b0;
      finish    <= '0;
      sp        <= '0;
      nmi_pend  <= 1'b0;
      int_ack_q <= 2'b00;
      err_q     <= 1'b0;
      nmi_q     <= nmi;
    end else begin
      // The NMI edge detector keeps running through RDY stalls; a new edge re-pends even while taken.
      nmi_q    <= nmi;
      nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
      if (rdy) begin
        upc_q     <= upc_n;
        we_q      <= ctrl[WE_BIT];
        int_ack_q <= {take_nmi, take_irq};
        if (fault)              err_q  <= 1'b1;
        if (ld_fin)             finish <= fin;
        if (push && !stk_full)  sp     <= sp + SP_W'(1);
        if (pop && !stk_empty)  sp     <= sp - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stack[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_useq_ctl.sv
// Bench for useq_ctl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based behavioural model of the sequencing rules.
module tb_useq_ctl;

  logic        clk = 1'b0;
  logic        reset, rdy, irq, nmi, I, D, cond;
  logic [7:0]  DB;
  logic [35:0] ctrl;
  logic [8:0]  upc;
  logic        sync, WE, B, err;
  logic [1:0]  int_ack;

  int tests = 0;
  int fails = 0;

  useq_ctl dut (
    .clk(clk), .reset(reset), .rdy(rdy), .irq(irq), .nmi(nmi), .I(I), .D(D),
    .cond(cond), .DB(DB), .ctrl(ctrl), .upc(upc), .sync(sync), .WE(WE), .B(B),
    .int_ack(int_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mk(input logic [2:0] op, input logic [6:0] link,
                                     input logic [4:0] fin, input logic we);
    logic [35:0] c;
    c        = '0;
    c[24:22] = op;
    c[6:0]   = link;
    c[14:10] = fin;
    c[28]    = we;
    return c;
  endfunction

  // Behavioural model state: architectural registers plus the return stack as a queue.
  bit         mvalid = 0;
  logic [8:0] m_upcq, n_upcq;
  logic       m_we, n_we, m_err, n_err, m_pend, n_pend, m_nmiq;
  logic [4:0] m_fin, n_fin;
  logic [1:0] m_ack, n_ack;
  logic [8:0] m_stk[$];
  logic [8:0] n_stk[$];

  always @(negedge clk) begin : model_cmp
    logic [8:0] eu, jmp;
    logic       es, tn, ti, nedge;
    logic [2:0] op;
    if (mvalid) begin
      n_stk  = m_stk;
      n_upcq = m_upcq; n_we = m_we; n_fin = m_fin; n_ack = m_ack; n_err = m_err;
      nedge  = nmi & ~m_nmiq;
      n_pend = m_pend | nedge;
      tn = 0; ti = 0; es = 0;
      op  = ctrl[24:22];
      jmp = {1'b1, D, ctrl[6:0]};
      eu  = m_upcq;
      if (reset) begin
        eu = 9'h160;
      end else if (rdy) begin
        case (op)
          3'd0, 3'd7: begin
            if (m_pend) begin eu = 9'h170; tn = 1; end
            else if (irq && !I) begin eu = 9'h168; ti = 1; end
            else eu = {1'b0, DB};
            es = !(tn || ti);
            if (op == 3'd7) n_err = 1;
          end
          3'd1: eu = jmp;
          3'd2: eu = {1'b1, D, 2'b10, m_fin};
          3'd3: begin eu = jmp; n_fin = ctrl[14:10]; end
          3'd4: begin
            eu = jmp;
            if (m_stk.size() == 4) begin n_stk[3] = m_upcq + 9'd1; n_err = 1; end
            else n_stk.push_back(m_upcq + 9'd1);
          end
          3'd5: begin
            if (m_stk.size() == 0) begin eu = 9'h160; n_err = 1; end
            else eu = n_stk.pop_back();
          end
          default: eu = cond ? jmp : m_upcq;
        endcase
        n_upcq = eu;
        n_we   = ctrl[28];
        n_ack  = {tn, ti};
        n_pend = nedge | (m_pend & ~tn);
      end
      chk("upc", upc, eu);
      chk("sync", sync, es);
      chk("WE", WE, m_we);
      chk("B", B, ctrl[8]);
      chk("int_ack", int_ack, m_ack);
      chk("err", err, m_err);
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_upcq = 9'h160; m_we = 0; m_fin = 0; m_stk.delete();
      m_pend = 0; m_ack = 0; m_err = 0; mvalid = 1;
    end else if (mvalid) begin
      m_upcq = n_upcq; m_we = n_we; m_fin = n_fin; m_stk = n_stk;
      m_pend = n_pend; m_ack = n_ack; m_err = n_err;
    end
    m_nmiq = nmi;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; rdy = 1; irq = 0; nmi = 0; I = 0; D = 0; cond = 0; DB = 0; ctrl = '0;

    // Reset held two cycles
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk("rst_upc", upc, 9'h160);
      chk("rst_we", WE, 0);
      chk("rst_err", err, 0);
      chk("rst_ack", int_ack, 0);
    end

    // Decode, next-with-save, finish
    tick(); reset = 0; ctrl = mk(3'd0, 0, 0, 0); DB = 8'hA9; #1;
    chk("dec_upc", upc, 9'h0A9); chk("dec_sync", sync, 1);
    tick(); ctrl = mk(3'd3, 7'h12, 5'h05, 1); D = 1; #1;
    chk("nsave_upc", upc, 9'h192);
    tick(); ctrl = mk(3'd2, 0, 0, 0); #1;
    chk("fin_upc", upc, 9'h1C5); chk("fin_we", WE, 1);

    // Call / return, then overflow the stack
    tick(); D = 0; ctrl = mk(3'd1, 7'h30, 0, 0); #1;
    chk("next_upc", upc, 9'h130);
    tick(); ctrl = mk(3'd4, 7'h20, 0, 0); #1;
    chk("call_upc", upc, 9'h120);
    tick(); ctrl = mk(3'd5, 0, 0, 0); #1;
    chk("ret_upc", upc, 9'h131);
    for (int k = 0; k < 5; k++) begin
      tick(); ctrl = mk(3'd4, 7'h20 + 7'(k), 0, 0); #1;
      chk("ncall_upc", upc, 9'h120 + 9'(k));
      chk("ncall_err", err, 0);
    end
    tick(); ctrl = mk(3'd1, 0, 0, 0); #1;
    chk("ovf_err", err, 1);

    // NMI over IRQ, then IRQ, then masked IRQ
    tick(); reset = 1; #1;
    tick(); reset = 0; ctrl = mk(3'd1, 7'h10, 0, 0); nmi = 1; irq = 1; I = 0; #1;
    chk("pre_nmi_upc", upc, 9'h110);
    tick(); ctrl = mk(3'd0, 0, 0, 0); DB = 8'h11; #1;
    chk("nmi_upc", upc, 9'h170); chk("nmi_sync", sync, 0);
    tick(); #1;
    chk("nmi_ack", int_ack, 2'b10); chk("irq_upc", upc, 9'h168);
    tick(); I = 1; DB = 8'h55; #1;
    chk("irq_ack", int_ack, 2'b01); chk("mask_upc", upc, 9'h055); chk("mask_sync", sync, 1);

    // Edge coinciding with NMI acceptance re-pends
    tick(); nmi = 0; ctrl = mk(3'd1, 7'h01, 0, 0); #1;
    tick(); nmi = 1; #1;
    tick(); nmi = 0; #1;
    tick(); nmi = 1; ctrl = mk(3'd0, 0, 0, 0); DB = 8'h22; #1;
    chk("repend1_upc", upc, 9'h170);
    tick(); #1;
    chk("repend2_upc", upc, 9'h170);
    tick(); #1;
    chk("repend3_upc", upc, 9'h022);

    // RDY stall with NMI edge inside it
    tick(); nmi = 0; ctrl = mk(3'd1, 7'h33, 0, 1); #1;
    chk("prestall_upc", upc, 9'h133);
    for (int k = 0; k < 3; k++) begin
      tick(); rdy = 0; ctrl = 36'({$urandom, $urandom}); nmi = (k >= 1); #1;
      chk("stall_upc", upc, 9'h133); chk("stall_sync", sync, 0); chk("stall_we", WE, 1);
    end
    tick(); rdy = 1; ctrl = mk(3'd0, 0, 0, 0); #1;
    chk("poststall_nmi", upc, 9'h170);
    tick(); ctrl = mk(3'd1, 7'h02, 0, 0); #1;
    chk("poststall_ack", int_ack, 2'b10);

    // WAIT polling, empty-stack return
    tick(); reset = 1; nmi = 0; #1;
    tick(); reset = 0; ctrl = mk(3'd1, 7'h05, 0, 0); #1;
    chk("prewait_upc", upc, 9'h105);
    for (int k = 0; k < 4; k++) begin
      tick(); ctrl = mk(3'd6, 7'h40, 0, 0); cond = 0; #1;
      chk("wait_upc", upc, 9'h105);
    end
    tick(); cond = 1; #1;
    chk("wait_done", upc, 9'h140);
    tick(); ctrl = mk(3'd5, 0, 0, 0); #1;
    chk("udf_upc", upc, 9'h160); chk("udf_err_before", err, 0);
    tick(); ctrl = mk(3'd1, 0, 0, 0); #1;
    chk("udf_err", err, 1);

    // Illegal op behaves as decode and flags err
    tick(); reset = 1; #1;
    tick(); reset = 0; I = 1; DB = 8'h3C; ctrl = mk(3'd7, 0, 0, 0); #1;
    chk("ill_upc", upc, 9'h03C); chk("ill_sync", sync, 1);
    tick(); ctrl = mk(3'd1, 0, 0, 0); #1;
    chk("ill_err", err, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      rdy   = ($urandom_range(0, 6) != 0);
      irq   = 1'($urandom);
      I     = 1'($urandom);
      D     = 1'($urandom);
      cond  = ($urandom_range(0, 3) == 0);
      DB    = 8'($urandom);
      if ($urandom_range(0, 9) == 0) nmi = ~nmi;
      ctrl  = 36'({$urandom, $urandom});
    end
    tick(); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
